seq_divider: RTL and testbench

- Iterative 32-bit integer divider for the RISC5 execute stage; the counterpart of the multiplier unit.
- Computes quotient and remainder of x DIV y / x MOD y with Oberon floor semantics.
- Holds the pipeline via stall while it iterates, using the same run/stall handshake as the multiplier.
- Produces BPC quotient bits per clock using a restoring shift-subtract datapath.

---
 rtl/seq_divider_pkg.sv | 34 +++
 rtl/seq_divider_div_step.sv | 32 +++
 rtl/seq_divider.sv | 173 +++++++++++++++++
 tb/tb_seq_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared constants and types for the iterative RISC5 divider.
//   W        : operand width (32).
//   cnt_t    : 6-bit iteration counter type, the divider's only control state.
//   CNT_IDLE : counter value while no divide is in flight.
//   iters()  : iterations per divide, W / BPC.
//   cnt_done(): counter value of the single result cycle, iters() + 1.
//   phase_e  : decoded view of the counter used by the control process.
package seq_divider_pkg;

  localparam int W     = 32;
  localparam int CNT_W = 6;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_IDLE = '0;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ITER,
    PH_DONE
  } phase_e;

  // N = W / BPC; BPC is a per-instance parameter, so N is derived through
  // these helpers rather than being a fixed package constant.
  function automatic int iters(input int bpc);
    return W / bpc;
  endfunction

  function automatic cnt_t cnt_done(input int bpc);
    return cnt_t'(W / bpc + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step
//   One combinational restoring shift-subtract step of the divider.
//   Ports:
//     r_in  [W-1:0] : partial remainder before the step
//     q_in  [W-1:0] : dividend/quotient shift register before the step
//     y     [W-1:0] : divisor (unsigned magnitude)
//     r_out [W-1:0] : partial remainder after the step
//     q_out [W-1:0] : shift register after the step, new quotient bit in bit 0
module seq_divider_div_step
  import seq_divider_pkg::*;
(
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] y,
  output logic [W-1:0] r_out,
  output logic [W-1:0] q_out
);

  // 33-bit shifted remainder: bit W may be set when r_in[W-1] was set, and
  // it must take part in the compare so the subtraction is not skipped.
  logic [W:0] shifted;
  logic       ge;

  always_comb begin
    shifted = {r_in, q_in[W-1]};
    ge      = (shifted >= {1'b0, y});
    // When ge is true the difference is below y, so the low W bits hold it.
    r_out   = ge ? (shifted[W-1:0] - y) : shifted[W-1:0];
    q_out   = {q_in[W-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Iterative 32-bit divider for the RISC5 execute stage. Computes x DIV y and
//   x MOD y with floor semantics (0 <= rem < y for y != 0), resolving BPC
//   quotient bits per clock with a restoring shift-subtract datapath, and holds
//   the pipeline through stall while it iterates.
//
//   Parameters:
//     BPC   : quotient bits per cycle, 1 or 2. Iterations N = 32 / BPC.
//   Ports:
//     clk   : system clock, rising edge
//     rst   : asynchronous active-low reset
//     run   : divide requested, held high until stall drops
//     u     : 1 = dividend is signed two's complement, 0 = unsigned
//     x     : dividend, stable while run is high
//     y     : divisor (unsigned magnitude), stable while run is high
//     stall : run & (cnt != N+1), combinational
//     quot  : quotient, valid when run & ~stall
//     rem   : remainder, valid when run & ~stall
//     dz    : divide-by-zero flag, present only with SEQ_DIVIDER_ZERO_FLAG_EN
//
//   Optional feature macro: SEQ_DIVIDER_ZERO_FLAG_EN adds the dz output,
//   captured as (y == 0) at load and held through the result cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         u,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         stall,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
  ,
  output logic         dz
`endif
);

  localparam int   N        = iters(BPC);
  localparam cnt_t CNT_DONE = cnt_done(BPC);

  cnt_t         cnt_q, cnt_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] q_q, q_d;
  logic         neg_q, neg_d;
  phase_e       phase;

  // Step chain: element 0 is the registered state, element BPC the result
  // of all steps taken in one cycle.
  logic [W-1:0] r_chain [BPC+1];
  logic [W-1:0] q_chain [BPC+1];

  assign r_chain[0] = r_q;
  assign q_chain[0] = q_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    seq_divider_div_step u_step (
      .r_in  (r_chain[i]),
      .q_in  (q_chain[i]),
      .y     (y),
      .r_out (r_chain[i+1]),
      .q_out (q_chain[i+1])
    );
  end

  always_comb begin
    if (cnt_q == CNT_IDLE) begin
      phase = PH_IDLE;
    end else if (cnt_q == CNT_DONE) begin
      phase = PH_DONE;
    end else begin
      phase = PH_ITER;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    r_d   = r_q;
    q_d   = q_q;
    neg_d = neg_q;
    if (!run) begin
      // Dropping run abandons any divide in flight; datapath contents are
      // don't-care until the next load.
      cnt_d = CNT_IDLE;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          neg_d = u & x[W-1];
          // -0x80000000 wraps to itself, which is the correct magnitude 2^31.
          q_d   = (u & x[W-1]) ? (W'(0) - x) : x;
          r_d   = '0;
          cnt_d = CNT_IDLE + cnt_t'(1);
        end
        PH_ITER: begin
          r_d   = r_chain[BPC];
          q_d   = q_chain[BPC];
          cnt_d = cnt_q + cnt_t'(1);
        end
        PH_DONE: begin
          cnt_d = CNT_IDLE;
        end
        default: begin
          cnt_d = CNT_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_IDLE;
      r_q   <= '0;
      q_q   <= '0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
      q_q   <= q_d;
      neg_q <= neg_d;
    end
  end

`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
  logic dz_q, dz_d;

  always_comb begin
    dz_d = dz_q;
    if (phase == PH_IDLE) begin
      dz_d = run & (y == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign dz = dz_q;
`endif

  assign stall = run & (cnt_q != CNT_DONE);

  // Floor correction for a negative dividend: an exact division just negates
  // the magnitude quotient; otherwise the quotient rounds down one further
  // (~Q = -Q-1) and the remainder is reflected into [0, y).
  always_comb begin
    quot = q_q;
    rem  = r_q;
    if (neg_q) begin
      if (r_q == '0) begin
        quot = W'(0) - q_q;
        rem  = '0;
      end else begin
        quot = ~q_q;
        rem  = y - r_q;
      end
    end
  end

  // N is kept visible for readers relating BPC to the iteration count.
  logic [31:0] n_iters;
  assign n_iters = 32'(N);
  logic unused_n;
  assign unused_n = ^n_iters;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Bench for seq_divider: one BPC=1 and one BPC=2 instance sharing u/x/y,
//   each with its own run. Results are compared against a reference computed
//   with plain integer division plus the floor-correction rules.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_a, run_b;
  logic        u;
  logic [31:0] x, y;
  logic        stall_a, stall_b;
  logic [31:0] quot_a, rem_a, quot_b, rem_b;
`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
  logic        dz_a, dz_b;
`endif

  always #5 clk = ~clk;

  seq_divider #(.BPC(1)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .run   (run_a),
    .u     (u),
    .x     (x),
    .y     (y),
    .stall (stall_a),
    .quot  (quot_a),
    .rem   (rem_a)
`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
    ,
    .dz    (dz_a)
`endif
  );

  seq_divider #(.BPC(2)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .run   (run_b),
    .u     (u),
    .x     (x),
    .y     (y),
    .stall (stall_b),
    .quot  (quot_b),
    .rem   (rem_b)
`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
    ,
    .dz    (dz_b)
`endif
  );

  logic        sel;
  logic        stall_m;
  logic [31:0] quot_m, rem_m;
  assign stall_m = sel ? stall_b : stall_a;
  assign quot_m  = sel ? quot_b  : quot_a;
  assign rem_m   = sel ? rem_b   : rem_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: magnitude division, then floor correction for a negative
  // signed dividend. Division by zero gives all-ones quotient, |x| remainder.
  task automatic ref_div(input logic uu, input logic [31:0] xx, input logic [31:0] yy,
                         output logic [31:0] eq, output logic [31:0] er);
    logic [31:0] ax, q, r;
    logic        ng;
    ng = uu & xx[31];
    ax = ng ? (32'd0 - xx) : xx;
    if (yy == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ax;
    end else begin
      q = ax / yy;
      r = ax % yy;
    end
    if (ng) begin
      if (r == 32'd0) begin
        q = 32'd0 - q;
      end else begin
        q = 32'd0 - q - 32'd1;
        r = yy - r;
      end
    end
    eq = q;
    er = r;
  endtask

  // Called at a falling edge; returns at the falling edge just after the
  // result cycle, with run still high so a following call runs back-to-back.
  task automatic do_div(input logic s, input logic uu, input logic [31:0] xx,
                        input logic [31:0] yy, input string tag);
    int          cyc;
    int          exp_len;
    logic [31:0] eq, er;
    exp_len = s ? 17 : 33;
    sel = s;
    u   = uu;
    x   = xx;
    y   = yy;
    if (s) run_b = 1'b1;
    else   run_a = 1'b1;
    ref_div(uu, xx, yy, eq, er);
    #1;
    cyc = 0;
    while (stall_m === 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val({tag, ".len"}, 32'(cyc), 32'(exp_len));
    check_val({tag, ".quot"}, quot_m, eq);
    check_val({tag, ".rem"}, rem_m, er);
`ifdef SEQ_DIVIDER_ZERO_FLAG_EN
    check_val({tag, ".dz"}, {31'd0, (s ? dz_b : dz_a)}, {31'd0, (yy == 32'd0)});
`endif
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    run_a = 1'b0;
    run_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s, uu, prev_s;
    logic [31:0] xx, yy;
    rst   = 1'b0;
    run_a = 1'b0;
    run_b = 1'b0;
    u     = 1'b0;
    x     = '0;
    y     = '0;
    sel   = 1'b0;

    // Reset state: stall follows run, outputs zero.
    #2 run_a = 1'b1;
    #1;
    check_val("rst.stall", {31'd0, stall_a}, 32'd1);
    check_val("rst.quot", quot_a, 32'd0);
    check_val("rst.rem", rem_a, 32'd0);
    run_a = 1'b0;
    #1;
    check_val("rst.stall_lo", {31'd0, stall_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_div(1'b0, 1'b0, 32'd100, 32'd7, "t1");
    idle_cycle();
    do_div(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "t2a");
    idle_cycle();
    do_div(1'b0, 1'b1, 32'hFFFF_FFF8, 32'd2, "t2b");
    idle_cycle();
    do_div(1'b0, 1'b1, 32'h8000_0000, 32'd1, "t3s");
    idle_cycle();
    do_div(1'b0, 1'b0, 32'h8000_0000, 32'd1, "t3u");
    idle_cycle();
    do_div(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, "t4");
    idle_cycle();
    do_div(1'b0, 1'b1, 32'hFFFF_FF00, 32'd0, "t4neg");
    idle_cycle();

    // Abort by dropping run at cycle 10.
    u = 1'b0; x = 32'd100; y = 32'd7; run_a = 1'b1;
    repeat (10) @(negedge clk);
    idle_cycle();
    do_div(1'b0, 1'b0, 32'd9, 32'd3, "t5abort");
    idle_cycle();

    // Asynchronous reset in the middle of iteration.
    u = 1'b0; x = 32'd1000; y = 32'd3; run_a = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("t5rst.stall", {31'd0, stall_a}, 32'd1);
    check_val("t5rst.quot", quot_a, 32'd0);
    check_val("t5rst.rem", rem_a, 32'd0);
    run_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_div(1'b0, 1'b0, 32'd1000, 32'd3, "t5after");
    idle_cycle();

    // Back-to-back with run held high, both iteration widths.
    do_div(1'b0, 1'b0, 32'd50, 32'd5, "t6a1");
    do_div(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, "t6a2");
    idle_cycle();
    do_div(1'b1, 1'b0, 32'd50, 32'd5, "t6b1");
    do_div(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, "t6b2");
    idle_cycle();
    do_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, "t6b3");
    idle_cycle();

    // Randomized operands, mixing widths, divisor ranges and back-to-back.
    prev_s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s  = ($urandom_range(0, 2) == 0);
      uu = 1'($urandom_range(0, 1));
      xx = $urandom;
      case ($urandom_range(0, 5))
        0:       yy = $urandom;
        1, 2:    yy = $urandom_range(1, 255);
        3:       yy = 32'd0;
        4:       yy = xx >> $urandom_range(1, 31);
        default: yy = $urandom & 32'h0000_FFFF;
      endcase
      if (s != prev_s || $urandom_range(0, 1) == 0) idle_cycle();
      do_div(s, uu, xx, yy, $sformatf("rnd%0d", i));
      prev_s = s;
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
